// File: rtl/systolic_feed_ctrl.sv
// Operand sequencer for an output-stationary systolic array.
// Latches A/B on start, then emits skewed west/north operand wavefronts.
module systolic_feed_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ARRAY_W      = 4,
  parameter int ARRAY_L      = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] matrix_a,
  input  logic [0:ARRAY_L-1][0:ARRAY_W-1][DATA_WIDTH-1:0] matrix_b,
  output logic [0:ARRAY_W-1][DATA_WIDTH-1:0] a_feed,
  output logic [0:ARRAY_W-1] a_valid,
  output logic [0:ARRAY_W-1][DATA_WIDTH-1:0] b_feed,
  output logic [0:ARRAY_W-1] b_valid,
  output logic pe_clear,
  output logic busy,
  output logic done,
  output logic [$clog2(ARRAY_L+ARRAY_W)-1:0] step
);

  localparam int F    = ARRAY_L + ARRAY_W - 1;
  localparam int SW   = $clog2(ARRAY_L + ARRAY_W);
  localparam int CMAX = (F > DRAIN_CYCLES) ? F : DRAIN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] a_lat;
  logic [0:ARRAY_L-1][0:ARRAY_W-1][DATA_WIDTH-1:0] b_lat;

  logic [0:ARRAY_W-1][DATA_WIDTH-1:0] a_feed_d, b_feed_d;
  logic [0:ARRAY_W-1] a_valid_d, b_valid_d;
  logic pe_clear_d, busy_d, done_d;
  logic [SW-1:0] step_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
        S_FEED: begin
          if (cnt_q == CW'(F - 1)) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Operands are captured only on the edge that accepts a pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat <= '0;
      b_lat <= '0;
    end else if (state_q == S_IDLE && state_d == S_LOAD) begin
      a_lat <= matrix_a;
      b_lat <= matrix_b;
    end
  end

  // Lane i carries element k-i; matching on i+l avoids a variable index.
  always_comb begin
    a_feed_d   = '0;
    a_valid_d  = '0;
    b_feed_d   = '0;
    b_valid_d  = '0;
    step_d     = '0;
    pe_clear_d = (state_d == S_LOAD);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    if (state_d == S_FEED) begin
      step_d = SW'(cnt_d);
      for (int i = 0; i < ARRAY_W; i++) begin
        for (int l = 0; l < ARRAY_L; l++) begin
          if (int'(cnt_d) == i + l) begin
            a_feed_d[i]  = a_lat[i][l];
            a_valid_d[i] = 1'b1;
            b_feed_d[i]  = b_lat[l][i];
            b_valid_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_feed   <= '0;
      a_valid  <= '0;
      b_feed   <= '0;
      b_valid  <= '0;
      pe_clear <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step     <= '0;
    end else begin
      a_feed   <= a_feed_d;
      a_valid  <= a_valid_d;
      b_feed   <= b_feed_d;
      b_valid  <= b_valid_d;
      pe_clear <= pe_clear_d;
      busy     <= busy_d;
      done     <= done_d;
      step     <= step_d;
    end
  end

endmodule
